// File: rtl/cpu_pkg.sv
// Shared CPU definitions: command width, requester encodings and the
// command-arbiter state type.
package cpu_pkg;

    localparam int CMD_W = 7;

    // Owner / grant-id encodings; also used as bit indices into grant vectors.
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage : cpu_pkg

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick. Purely combinational; the caller owns the
// last-grant pointer and decides when it advances.
module rr_arbiter2
    import cpu_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] grant,
    output logic       gnt_id
);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // through this block can leave a value unassigned and infer a latch.
        gnt_id = REQ_A;
        grant  = 2'b00;

        case (req)
            2'b01:   gnt_id = REQ_A;
            2'b10:   gnt_id = REQ_B;
            2'b11:   gnt_id = (last_grant == REQ_A) ? REQ_B : REQ_A;
            default: gnt_id = REQ_A;
        endcase

        if (en && (req != 2'b00)) begin
            grant[gnt_id] = 1'b1;
        end
    end

endmodule : rr_arbiter2

// File: rtl/cmd_arbiter.sv
// Round-robin command arbiter for two requesters in front of the control
// unit: issues one command, holds the datapath, then reports completion.
module cmd_arbiter
    import cpu_pkg::*;
#(
    parameter int CMD_W       = cpu_pkg::CMD_W,
    parameter int BUSY_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             a_valid,
    input  logic [CMD_W-1:0] a_cmd,
    output logic             a_ready,
    output logic             a_done,
    output logic             a_err,

    input  logic             b_valid,
    input  logic [CMD_W-1:0] b_cmd,
    output logic             b_ready,
    output logic             b_done,
    output logic             b_err,

    output logic [CMD_W-1:0] cmd_out,
    output logic             cmd_out_valid,
    input  logic             p_error,
    output logic             busy,
    output logic             owner
);

    localparam int CNT_W = $clog2(BUSY_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUSY_CYCLES - 1);

    arb_state_t       state;
    logic [CMD_W-1:0] cmd_q;
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic             last_grant;

    logic             arb_en;
    logic [1:0]       grant;
    logic             gnt_id;
    logic             xfer;
    logic [CMD_W-1:0] sel_cmd;
    logic             err_next;

    // Grants are withheld while reset is asserted so nothing is accepted
    // in a cycle whose state update the reset is about to discard.
    assign arb_en = (state == IDLE) && !rst;

    rr_arbiter2 u_rr_arbiter2 (
        .req        ({b_valid, a_valid}),
        .last_grant (last_grant),
        .en         (arb_en),
        .grant      (grant),
        .gnt_id     (gnt_id)
    );

    assign a_ready  = grant[REQ_A];
    assign b_ready  = grant[REQ_B];
    assign xfer     = grant[REQ_A] | grant[REQ_B];
    assign sel_cmd  = (gnt_id == REQ_B) ? b_cmd : a_cmd;
    assign err_next = err_q | p_error;

    assign busy    = (state != IDLE);
    assign cmd_out = cmd_q;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every register in
        // this block sees the pre-edge value of every other register.
        if (rst) begin
            state         <= IDLE;
            cmd_q         <= '0;
            cnt           <= '0;
            err_q         <= 1'b0;
            last_grant    <= REQ_B;
            owner         <= REQ_A;
            cmd_out_valid <= 1'b0;
            a_done        <= 1'b0;
            a_err         <= 1'b0;
            b_done        <= 1'b0;
            b_err         <= 1'b0;
        end else begin
            cmd_out_valid <= 1'b0;
            a_done        <= 1'b0;
            a_err         <= 1'b0;
            b_done        <= 1'b0;
            b_err         <= 1'b0;

            case (state)
                IDLE: begin
                    if (xfer) begin
                        cmd_q         <= sel_cmd;
                        owner         <= gnt_id;
                        last_grant    <= gnt_id;
                        err_q         <= 1'b0;
                        cmd_out_valid <= 1'b1;
                        state         <= ISSUE;
                    end
                end

                ISSUE: begin
                    err_q <= err_next;
                    cnt   <= CNT_LOAD;
                    state <= WAIT;
                end

                WAIT: begin
                    err_q <= err_next;
                    if (cnt == '0) begin
                        // Completion flags are registered here so they are
                        // visible exactly during the RESP cycle.
                        if (owner == REQ_B) begin
                            b_done <= 1'b1;
                            b_err  <= err_next;
                        end else begin
                            a_done <= 1'b1;
                            a_err  <= err_next;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_single_ready : assert property (@(posedge clk) !(a_ready && b_ready));

    a_cnt_bound : assert property (@(posedge clk) disable iff (rst)
        (state == WAIT) |-> (int'(cnt) < BUSY_CYCLES));

endmodule : cmd_arbiter

// File: doc/cmd_arbiter.md
# cmd_arbiter

Two-requester round-robin command arbiter in front of the CPU `control` unit. It accepts 7-bit commands from two independent sources, A and B, over valid/ready handshakes. It issues one command at a time to the control unit and holds the shared ALU/memory datapath for a fixed busy window. It returns a completion pulse, with a sticky ALU-error flag, to whichever requester owned the command.

## Interface
Parameters:
- `CMD_W`, 7: command width; matches control-unit `cmd_in`.
- `BUSY_CYCLES`, 3: cycles the datapath is held after issue. Legal values are ≥1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `a_valid`  in  1  requester A has a command.
- `a_cmd`  in  CMD_W  requester A command.
- `a_ready`  out  1  A's command is accepted this cycle.
- `a_done`  out  1  one-cycle completion pulse for A.
- `a_err`  out  1  valid with `a_done`; an error was seen during A's command.
- `b_valid`, `b_cmd`, `b_ready`, `b_done`, `b_err`: same as A, for requester B.
- `cmd_out`  out  CMD_W  command to control unit `cmd_in`.
- `cmd_out_valid`  out  1  one-cycle issue strobe.
- `p_error`  in  1  ALU error from the datapath.
- `busy`  out  1  high in every state except IDLE.
- `owner`  out  1  current/last owner; 0 = A, 1 = B.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any valid is high, grant one requester. `x_ready` is driven combinationally: `(state==IDLE) && grant==x`.
  - On transfer (valid & ready): latch cmd into `cmd_q`, set `owner`, clear `err_q`, go to ISSUE.
- Arbitration:
  - One request → that requester wins.
  - Both requesting → the requester that is not `last_grant` wins.
  - `last_grant` resets to B, so A wins the first tie.
  - `last_grant` updates on transfer.
- ISSUE: `cmd_out_valid`=1, `cmd_out`=`cmd_q`. Load `cnt` = BUSY_CYCLES-1. Go to WAIT.
- WAIT:
  - If `cnt`==0, go to RESP; otherwise decrement.
  - Occupies exactly BUSY_CYCLES cycles.
- Error capture: `err_q |= p_error` in ISSUE and WAIT cycles. `p_error` is ignored in IDLE and RESP.
- RESP: pulse `owner`'s `x_done`=1 and `x_err`=`err_q`. Go to IDLE.
- `cmd_out` holds `cmd_q` from ISSUE until the next issue. Only `cmd_out_valid` qualifies it.
- Requester obligations: hold valid and cmd stable until ready. Dropping valid before ready is legal and withdraws the request.
- `cnt` width: `$clog2(BUSY_CYCLES+1)`; it never underflows.

## Timing
- Reset values: state=IDLE, `cmd_q`=`cmd_out`=0, `cmd_out_valid`=0, `a_done`/`b_done`/`a_err`/`b_err`=0, `busy`=0, `owner`=0, `last_grant`=B, `err_q`=0, `cnt`=0.
- Acceptance at cycle T gives:
  - ISSUE at T+1.
  - WAIT at T+2 … T+1+BUSY_CYCLES.
  - RESP (done pulse) at T+2+BUSY_CYCLES; this is T+5 at the default.
- Earliest next accept is T+3+BUSY_CYCLES. Throughput is one command per BUSY_CYCLES+3 cycles.
- Zero-cycle accept: ready is combinational from state and valid; there is no skid buffer.
- Reset mid-operation:
  - `rst` high at any state → IDLE on the next edge.
  - The in-flight command is dropped: no done pulse and no `cmd_out_valid`.
  - `last_grant` returns to B.
- A `p_error` arriving in the same cycle as the RESP transition is not counted.
- Both valids in the same cycle → exactly one ready is asserted; never both.

## Structure
- Shared package `cpu_pkg`:
  - `arb_state_t` enum (IDLE, ISSUE, WAIT, RESP).
  - `CMD_W` constant.
  - `REQ_A`/`REQ_B` owner encodings.
- One sub-module, `rr_arbiter2`:
  - Inputs: `req[1:0]`, `last_grant`, `en`.
  - Outputs: `grant`, `gnt_id`.
  - Purely combinational; the pointer register stays in `cmd_arbiter`.
- Top-level instantiation: `cmd_out` → `control.cmd_in`; `control.p_error` source → `p_error`.

## Test plan
- Reset: `rst`=1 for 2 cycles with both valids high → no ready, all outputs at their reset values, `busy`=0.
- Single request: A valid with `a_cmd`=7'h15 at T → `a_ready`=1 at T; `cmd_out_valid`=1 with `cmd_out`=7'h15 at T+1; `a_done`=1, `a_err`=0 at T+5; `busy` high T+1…T+5.
- Contention: A=7'h11 and B=7'h22 both held from T → A accepted at T, B accepted at T+6, issues observed as 11 then 22. Both re-requested at T+12 → A accepted at T+12 (strict alternation).
- Error: A command accepted at T with a one-cycle `p_error` pulse at T+3 → `a_err`=1 with `a_done` at T+5. Next A command with no error → `a_err`=0.
- Reset mid-op: B accepted at T, `rst`=1 at T+3 → no `b_done`, IDLE and `busy`=0 at T+4. B still valid after `rst` drops → `b_ready` at T+4.
- Back-to-back single source: B held valid continuously → accepts at T, T+6, T+12, one `cmd_out_valid` per accept, `a_ready` never asserted.
